esm_remap_ctrl: RTL and testbench
=================================

// Module: esm_remap_ctrl
// PURPOSE
//  Epoch scheduler for the ESM register-remap table. Counts issued instructions and, at each
//  epoch boundary or on a forced request, stalls issue and drains the pipe. It then drives a
//  sequence of LFSR-chosen pairwise swaps into the ESM mapping table and pulses commit.
//  Sits between the decode/issue stage and ESM; ESM applies swaps and commit, not this block.
// PARAMETERS
//  Instruction_word_size  32      instruction width
//  EPOCH_LEN              16      instructions per remap epoch (>=2)
//  regnum                 16      mapping-table entries (power of 2); IDXW=$clog2(regnum)
//  DRAIN_CYC              3       stall cycles before first swap (>=1)
//  LFSR_SEED              16'hACE1 reset value of swap LFSR (non-zero)
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     synchronous active-high reset
//  instr_valid   in   1     instr_in valid this cycle
//  Instr_in      in   Instruction_word_size  instruction being issued to ESM
//  RegWrite      in   1     decode control, for the optional feature only
//  force_remap   in   1     request an immediate remap, level-sampled in COUNT only
//  stall         out  1     hold issue upstream
//  swap_we       out  1     swap strobe to ESM table
//  swap_a        out  IDXW  first swap index
//  swap_b        out  IDXW  second swap index
//  remap_commit  out  1     one-cycle pulse: new mapping valid
//  epoch_cnt     out  $clog2(EPOCH_LEN)  instructions counted in current epoch
// BEHAVIOUR
//  - Reset: state=COUNT, epoch_cnt=0, LFSR=LFSR_SEED, i=regnum-1; all outputs 0.
//  - Moore FSM. All outputs are decoded from registered state, so there is no comb in->out path.
//    COUNT:   a counted instruction (instr_valid & !stall) increments epoch_cnt.
//             A counted instruction with epoch_cnt==EPOCH_LEN-1 goes to DRAIN and clears epoch_cnt.
//             force_remap=1 also goes to DRAIN and clears epoch_cnt.
//             Expiry and force in the same cycle produce ONE remap.
//    DRAIN:   stall=1 for exactly DRAIN_CYC cycles, then SHUFFLE.
//    SHUFFLE: regnum-1 cycles, i counts regnum-1 down to 1.
//             Each cycle: swap_we=1, swap_a=i, swap_b=LFSR[IDXW-1:0]; if that is 0, swap_b=i (no-op).
//             Entry 0 (x0) is never moved. LFSR advances only in SHUFFLE.
//             After i==1: COMMIT, and i reloads to regnum-1.
//    COMMIT:  remap_commit=1, stall=1 for 1 cycle, then COUNT.
//  - stall = (state!=COUNT). Instructions presented while stall=1 are ignored (not counted).
//  - Latency: a counted instruction at the boundary in cycle t gives stall=1 from t+1.
//    Total stall = DRAIN_CYC+regnum = 19 cycles with defaults.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; never reaches 0.
//  - force_remap outside COUNT is ignored (not queued).
//  - rst in any state, including mid-SHUFFLE: full reset values next cycle and LFSR reseeded.
//    A partial swap sequence is left uncommitted; ESM must reset its table with the same rst.
//  - swap_a/swap_b are 0 when swap_we=0.
// CONFIGURATION
//  ESM_REMAP_NOP_FILTER_EN
//   defined:   an instruction is counted only if RegWrite=1 and Instr_in!=32'h00000013 (NOP).
//              force_remap is unaffected.
//   undefined: every instr_valid & !stall is counted; RegWrite is unused.
// STRUCTURE
//  - Package esm_pkg: state enum {COUNT,DRAIN,SHUFFLE,COMMIT}, LFSR tap constant (16'hB400),
//    NOP_INSTR constant (32'h00000013).
//  - Sub-module esm_lfsr16: clk, rst, adv, seed param, 16-bit state out.
//  - FSM, counters and output decode stay in esm_remap_ctrl.
// TESTING
//  1 rst=1 for 2 cycles, then 0 -> stall=0, swap_we=0, remap_commit=0, epoch_cnt=0.
//  2 16 back-to-back valid ADDs (32'h00C58533)
//    -> stall=1 from the cycle after the 16th; swap_we=1 for 15 cycles, swap_a 15..1;
//       remap_commit pulses once; stall low 19 cycles after it rose.
//  3 200 consecutive epochs -> swap_b never 0 when swap_we=1; replaying swaps on a model
//    table keeps map[0]==0 and the table a permutation.
//  4 5 instrs, then force_remap=1 for 1 cycle -> DRAIN next cycle; epoch_cnt=0.
//    force_remap and boundary in the same cycle -> exactly one remap_commit.
//  5 rst pulsed when swap_a==9 -> next cycle stall=0, swap_we=0, epoch_cnt=0.
//    The next epoch's swap_b sequence equals the post-reset sequence from test 2.
//  6 With ESM_REMAP_NOP_FILTER_EN: 16 NOPs -> no stall, epoch_cnt=0;
//    16 ADDs with RegWrite=1 -> remap.
//    Without the macro: 16 NOPs -> remap. instr_valid held high during stall is never counted.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared state encoding, LFSR taps and helpers for the ESM remap controller.
package esm_pkg;

    typedef enum logic [1:0] {
        COUNT,
        DRAIN,
        SHUFFLE,
        COMMIT
    } esm_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Galois right-shift for x^16+x^14+x^13+x^11+1; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

endpackage

// File: rtl/esm_lfsr16.sv
// 16-bit Galois LFSR that only steps when adv is high; reloads SEED on rst.
module esm_lfsr16
    import esm_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (adv) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/esm_remap_ctrl.sv
// Epoch scheduler for the ESM register-remap table: counts issue, drains, drives swaps, commits.
// Optional build macro ESM_REMAP_NOP_FILTER_EN: count only RegWrite=1 non-NOP instructions.
module esm_remap_ctrl
    import esm_pkg::*;
#(
    parameter int          Instruction_word_size = 32,
    parameter int          EPOCH_LEN             = 16,
    parameter int          regnum                = 16,
    parameter int          DRAIN_CYC             = 3,
    parameter logic [15:0] LFSR_SEED             = 16'hACE1,
    localparam int         IDXW                  = $clog2(regnum),
    localparam int         ECW                   = $clog2(EPOCH_LEN)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             instr_valid,
    input  logic [Instruction_word_size-1:0] Instr_in,
    input  logic                             RegWrite,
    input  logic                             force_remap,
    output logic                             stall,
    output logic                             swap_we,
    output logic [IDXW-1:0]                  swap_a,
    output logic [IDXW-1:0]                  swap_b,
    output logic                             remap_commit,
    output logic [ECW-1:0]                   epoch_cnt
);

    localparam int             DCW        = $clog2(DRAIN_CYC + 1);
    localparam logic [IDXW-1:0] IDX_TOP    = IDXW'(regnum - 1);
    localparam logic [ECW-1:0]  EPOCH_LAST = ECW'(EPOCH_LEN - 1);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    esm_state_t      state;
    esm_state_t      state_nxt;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] idx_nxt;
    logic [DCW-1:0]  drain_cnt;
    logic [DCW-1:0]  drain_cnt_nxt;
    logic [ECW-1:0]  epoch_nxt;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_nxt;
    logic            lfsr_adv;
    logic            counted;
    logic [IDXW-1:0] pick;

    assign lfsr_adv = (state == SHUFFLE);

    esm_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (lfsr_adv),
        .state (lfsr)
    );

    // Value the LFSR will hold next cycle, so the registered swap_b lines up with it.
    assign lfsr_nxt = lfsr_adv ? lfsr_step(lfsr) : lfsr;

`ifdef ESM_REMAP_NOP_FILTER_EN
    assign counted = instr_valid && (state == COUNT) && RegWrite
                     && (Instr_in != Instruction_word_size'(NOP_INSTR));
`else
    logic unused_inputs;
    assign unused_inputs = ^{RegWrite, Instr_in};
    assign counted       = instr_valid && (state == COUNT);
`endif

    always_comb begin
        state_nxt     = state;
        epoch_nxt     = epoch_cnt;
        drain_cnt_nxt = drain_cnt;
        idx_nxt       = idx;
        case (state)
            COUNT: begin
                if (force_remap || (counted && (epoch_cnt == EPOCH_LAST))) begin
                    state_nxt = DRAIN;
                    epoch_nxt = '0;
                end else if (counted) begin
                    epoch_nxt = epoch_cnt + ECW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = SHUFFLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + DCW'(1);
                end
            end
            SHUFFLE: begin
                if (idx == IDXW'(1)) begin
                    state_nxt = COMMIT;
                    idx_nxt   = IDX_TOP;
                end else begin
                    idx_nxt = idx - IDXW'(1);
                end
            end
            COMMIT: begin
                state_nxt = COUNT;
            end
            default: begin
                state_nxt = COUNT;
            end
        endcase
        // A zero pick would move x0, so it degrades to a self-swap.
        pick = (lfsr_nxt[IDXW-1:0] == '0) ? idx_nxt : lfsr_nxt[IDXW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COUNT;
            epoch_cnt    <= '0;
            drain_cnt    <= '0;
            idx          <= IDX_TOP;
            stall        <= 1'b0;
            swap_we      <= 1'b0;
            swap_a       <= '0;
            swap_b       <= '0;
            remap_commit <= 1'b0;
        end else begin
            state        <= state_nxt;
            epoch_cnt    <= epoch_nxt;
            drain_cnt    <= drain_cnt_nxt;
            idx          <= idx_nxt;
            stall        <= (state_nxt != COUNT);
            swap_we      <= (state_nxt == SHUFFLE);
            swap_a       <= (state_nxt == SHUFFLE) ? idx_nxt : '0;
            swap_b       <= (state_nxt == SHUFFLE) ? pick : '0;
            remap_commit <= (state_nxt == COMMIT);
        end
    end

endmodule

// File: tb/tb_esm_remap_ctrl.sv
// Directed bench for esm_remap_ctrl: reset, counting/force vector table, full epochs against
// an LFSR/permutation model, mid-shuffle reset, and NOP handling in either build.
module tb_esm_remap_ctrl;

    localparam logic [31:0] ADD_INSTR = 32'h00C58533;
    localparam logic [31:0] NOP_WORD  = 32'h00000013;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        reg_write;
    logic        force_remap;
    logic        stall;
    logic        swap_we;
    logic [3:0]  swap_a;
    logic [3:0]  swap_b;
    logic        remap_commit;
    logic [3:0]  epoch_cnt;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] model_lfsr;
    int          model_map [16];
    logic [3:0]  bseq [15];

    typedef struct {
        logic       v;
        logic       frc;
        logic       ex_stall;
        logic       ex_we;
        logic [3:0] ex_a;
        logic [3:0] ex_b;
        logic       ex_cm;
        logic [3:0] ex_cnt;
    } vec_t;

    vec_t vecs [15];

    esm_remap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .Instr_in     (instr_in),
        .RegWrite     (reg_write),
        .force_remap  (force_remap),
        .stall        (stall),
        .swap_we      (swap_we),
        .swap_a       (swap_a),
        .swap_b       (swap_b),
        .remap_commit (remap_commit),
        .epoch_cnt    (epoch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rw,
                                 input logic frc);
        instr_valid = v;
        instr_in    = ins;
        reg_write   = rw;
        force_remap = frc;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic st, input logic we, input logic [3:0] a,
                            input logic [3:0] b, input logic cm, input logic [3:0] cnt);
        checkOutput({tag, ".stall"}, 32'(stall), 32'(st));
        checkOutput({tag, ".swap_we"}, 32'(swap_we), 32'(we));
        checkOutput({tag, ".swap_a"}, 32'(swap_a), 32'(a));
        checkOutput({tag, ".swap_b"}, 32'(swap_b), 32'(b));
        checkOutput({tag, ".remap_commit"}, 32'(remap_commit), 32'(cm));
        checkOutput({tag, ".epoch_cnt"}, 32'(epoch_cnt), 32'(cnt));
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic model_reset();
        model_lfsr = SEED;
        for (int i = 0; i < 16; i++) model_map[i] = i;
    endtask

    task automatic model_next_b(input logic [3:0] a, output logic [3:0] b);
        b          = (model_lfsr[3:0] == 4'd0) ? a : model_lfsr[3:0];
        model_lfsr = model_step(model_lfsr);
    endtask

    task automatic replay_swap(input logic [3:0] a, input logic [3:0] b);
        int t;
        t            = model_map[a];
        model_map[a] = model_map[b];
        model_map[b] = t;
    endtask

    task automatic check_perm();
        logic [15:0] seen;
        seen = '0;
        for (int i = 0; i < 16; i++) seen[model_map[i][3:0]] = 1'b1;
        checkOutput("map0_fixed", 32'(model_map[0]), 32'd0);
        checkOutput("map_permutation", 32'(seen), 32'hFFFF);
    endtask

    // Shuffle from first_a down to 1, then commit and resume; instr_valid stays as driven.
    task automatic shuffleCheck(input int first_a, input int abort_a);
        logic [3:0] b;
        for (int a = first_a; a >= 1; a--) begin
            tick();
            model_next_b(4'(a), b);
            checkAll("shuffle", 1'b1, 1'b1, 4'(a), b, 1'b0, 4'd0);
            checkOutput("swap_b_nonzero", 32'(swap_b != 4'd0), 32'd1);
            bseq[15 - a] = swap_b;
            if (swap_we) replay_swap(swap_a, swap_b);
            if (a == abort_a) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                checkAll("reset_mid_shuffle", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
                model_reset();
                instr_valid = 1'b0;
                return;
            end
        end
        tick();
        checkAll("commit", 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0);
        tick();
        checkAll("resume", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        instr_valid = 1'b0;
        check_perm();
    endtask

    task automatic runEpoch(input logic [31:0] ins, input logic force_last, input int abort_a);
        for (int n = 1; n <= 16; n++) begin
            applyStimulus(1'b1, ins, 1'b1, (n == 16) && force_last);
            if (n < 16) checkAll("epoch_count", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'(n));
            else        checkAll("epoch_boundary", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        end
        force_remap = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checkAll("drain", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        end
        shuffleCheck(15, abort_a);
    endtask

    initial begin
        logic [3:0] dummy_b;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_in    = 32'd0;
        reg_write   = 1'b0;
        force_remap = 1'b0;
        model_reset();

        tick();
        tick();
        checkAll("reset_held", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        rst = 1'b0;
        tick();
        checkAll("reset_release", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);

        // Counting with gaps, forced remap after five, ignored inputs in DRAIN, first swaps.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd2};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd3};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd3};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd4};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd5};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 4'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 4'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 4'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 4'd1,  1'b0, 4'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0, 4'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 4'd8,  1'b0, 4'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 4'd12, 1'b0, 4'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd11, 4'd14, 1'b0, 4'd0};
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].v, ADD_INSTR, 1'b1, vecs[i].frc);
            checkAll($sformatf("vec%0d", i), vecs[i].ex_stall, vecs[i].ex_we, vecs[i].ex_a,
                     vecs[i].ex_b, vecs[i].ex_cm, vecs[i].ex_cnt);
            if (vecs[i].ex_we) begin
                model_next_b(vecs[i].ex_a, dummy_b);
                replay_swap(swap_a, swap_b);
            end
        end
        force_remap = 1'b0;
        shuffleCheck(10, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("force_not_queued", 32'(stall), 32'd0);
        end

        runEpoch(ADD_INSTR, 1'b0, 0);

        // Boundary and force together must give a single remap.
        runEpoch(ADD_INSTR, 1'b1, 0);
        for (int i = 0; i < 25; i++) begin
            tick();
            checkOutput("single_remap", 32'({stall, remap_commit}), 32'd0);
        end

        for (int e = 0; e < 200; e++) runEpoch(ADD_INSTR, 1'b0, 0);

        runEpoch(ADD_INSTR, 1'b0, 9);
        runEpoch(ADD_INSTR, 1'b0, 0);
        checkOutput("post_reset_b0", 32'(bseq[0]), 32'd1);
        checkOutput("post_reset_b1", 32'(bseq[1]), 32'd14);
        checkOutput("post_reset_b2", 32'(bseq[2]), 32'd8);
        checkOutput("post_reset_b3", 32'(bseq[3]), 32'd12);
        checkOutput("post_reset_b4", 32'(bseq[4]), 32'd14);

`ifdef ESM_REMAP_NOP_FILTER_EN
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, NOP_WORD, 1'b1, 1'b0);
            checkAll("nop_filtered", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        end
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, ADD_INSTR, 1'b0, 1'b0);
            checkAll("no_regwrite_filtered", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        end
        instr_valid = 1'b0;
        runEpoch(ADD_INSTR, 1'b0, 0);
`else
        runEpoch(NOP_WORD, 1'b0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
